// File: rtl/image_mem_host_pkg.sv
// Shared types and image geometry for the accelerator memory host.
//   word_t       32-bit memory word (4 pixels)
//   halfword_t   16-bit half word
//   host_state_t job sequencer state
package image_mem_host_pkg;

   localparam int ADDR_W       = 16;
   localparam int DEPTH        = 50688;
   localparam int IMG_W        = 352;
   localparam int IMG_H        = 288;
   localparam int PIX_PER_WORD = 4;
   localparam int IMG_WORDS    = IMG_W * IMG_H / PIX_PER_WORD;
   localparam int RESULT_BASE  = IMG_WORDS;

   typedef logic [31:0] word_t;
   typedef logic [15:0] halfword_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DUMP
   } host_state_t;

endpackage

// File: rtl/image_mem_host_word_ram.sv
// Single-port synchronous word RAM, DEPTH x 32, one-cycle read latency,
// write-first (a write also presents the written word on rdata).
//   clk    clock
//   en     access enable
//   we     1 = write, 0 = read
//   addr   word address (caller guarantees addr < DEPTH when en=1)
//   wdata  write data
//   rdata  registered read data, holds between accesses
module image_mem_host_word_ram
   import image_mem_host_pkg::*;
#(
   parameter int DEPTH  = 50688,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  word_t             wdata,
   output word_t             rdata
);

   word_t mem_q [DEPTH];
   word_t rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[addr] <= wdata;
            rdata_q     <= wdata;
         end else begin
            rdata_q     <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/image_mem_host.sv
// Host end of the accelerator memory/start/finish interface. Streams one
// image into the word RAM, pulses acc_start, serves the acc bus until
// acc_finish, then streams the result region out through a 2-entry skid.
//   clk, reset             clock, async active-low reset
//   cmd_go / busy / done   job control and status; err = sticky acc range fault
//   in_valid/ready/data    image input stream
//   out_valid/ready/data   result output stream
//   acc_*                  accelerator memory bus and start/finish handshake
//
// state | meaning
// IDLE  | waiting for cmd_go
// LOAD  | accepting IMG_WORDS input words into address 0..
// RUN   | RAM owned by the acc bus; first cycle pulses acc_start
// DUMP  | reading RESULT_BASE.. out through the skid buffer
module image_mem_host
   import image_mem_host_pkg::*;
#(
   parameter int ADDR_W      = image_mem_host_pkg::ADDR_W,
   parameter int DEPTH       = image_mem_host_pkg::DEPTH,
   parameter int IMG_WORDS   = image_mem_host_pkg::IMG_WORDS,
   parameter int RESULT_BASE = image_mem_host_pkg::RESULT_BASE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_go,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   input  logic [ADDR_W-1:0] acc_addr,
   output logic [31:0]       acc_dataR,
   input  logic [31:0]       acc_dataW,
   input  logic              acc_en,
   input  logic              acc_we,
   output logic              acc_start,
   input  logic              acc_finish
);

   host_state_t       state_q, state_d;
   logic [ADDR_W-1:0] load_addr_q, load_addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] issue_left_q, issue_left_d;
   logic [ADDR_W-1:0] out_left_q, out_left_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              start_q, start_d;
   logic              acc_pend_q, acc_pend_d;
   logic              acc_oor_q, acc_oor_d;
   word_t             acc_hold_q, acc_hold_d;
   logic              dump_pend_q, dump_pend_d;
   word_t             skid_q [2];
   word_t             skid_d [2];
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [1:0]        skid_cnt_q, skid_cnt_d;

   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   word_t             ram_wdata, ram_rdata;
   logic              acc_oor, pop, dump_issue;
   logic [2:0]        occ;

   image_mem_host_word_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == LOAD);
   assign done      = done_q;
   assign err       = err_q;
   assign acc_start = start_q;
   assign out_valid = (skid_cnt_q != 2'd0);
   assign out_data  = skid_q[rd_ptr_q];
   assign pop       = out_valid & out_ready;
   assign acc_oor   = (32'(acc_addr) >= 32'(DEPTH));

   // Read data appears the cycle after the request, then holds until the next read.
   assign acc_dataR = acc_pend_q ? (acc_oor_q ? '0 : ram_rdata) : acc_hold_q;

   // Occupancy once this cycle's pop and in-flight read settle; issuing is safe
   // while that leaves room for one more word.
   assign occ        = {1'b0, skid_cnt_q} + {2'b00, dump_pend_q} - {2'b00, pop};
   assign dump_issue = (state_q == DUMP) && (issue_left_q != '0) && (occ <= 3'd1);

   always_comb begin
      state_d      = state_q;
      load_addr_d  = load_addr_q;
      rd_addr_d    = rd_addr_q;
      issue_left_d = issue_left_q;
      out_left_d   = out_left_q;
      err_d        = err_q;
      done_d       = 1'b0;
      start_d      = 1'b0;
      acc_pend_d   = 1'b0;
      acc_oor_d    = 1'b0;
      acc_hold_d   = acc_dataR;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = load_addr_q;
      ram_wdata    = in_data;

      case (state_q)
         IDLE: begin
            if (cmd_go) begin
               state_d     = LOAD;
               load_addr_d = '0;
               err_d       = 1'b0;
            end
         end
         LOAD: begin
            if (in_valid) begin
               ram_en = 1'b1;
               ram_we = 1'b1;
               if (load_addr_q == ADDR_W'(IMG_WORDS - 1)) begin
                  state_d = RUN;
                  start_d = 1'b1;
               end else begin
                  load_addr_d = load_addr_q + 1'b1;
               end
            end
         end
         RUN: begin
            ram_addr  = acc_addr;
            ram_wdata = acc_dataW;
            if (acc_en) begin
               if (acc_oor) begin
                  err_d = 1'b1;
               end else begin
                  ram_en = 1'b1;
                  ram_we = acc_we;
               end
               acc_pend_d = ~acc_we;
               acc_oor_d  = acc_oor;
            end
            // finish is ignored while the start pulse is still on the wire
            if (!start_q && acc_finish) begin
               state_d      = DUMP;
               rd_addr_d    = ADDR_W'(RESULT_BASE);
               issue_left_d = ADDR_W'(IMG_WORDS);
               out_left_d   = ADDR_W'(IMG_WORDS);
            end
         end
         DUMP: begin
            ram_addr = rd_addr_q;
            if (dump_issue) begin
               ram_en       = 1'b1;
               rd_addr_d    = rd_addr_q + 1'b1;
               issue_left_d = issue_left_q - 1'b1;
            end
            if (pop) begin
               out_left_d = out_left_q - 1'b1;
               if (out_left_q == ADDR_W'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dump_pend_d = dump_issue;
      skid_d      = skid_q;
      wr_ptr_d    = wr_ptr_q ^ dump_pend_q;
      rd_ptr_d    = rd_ptr_q ^ pop;
      skid_cnt_d  = skid_cnt_q + {1'b0, dump_pend_q} - {1'b0, pop};
      if (dump_pend_q) begin
         skid_d[wr_ptr_q] = ram_rdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         load_addr_q  <= '0;
         rd_addr_q    <= '0;
         issue_left_q <= '0;
         out_left_q   <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         start_q      <= 1'b0;
         acc_pend_q   <= 1'b0;
         acc_oor_q    <= 1'b0;
         acc_hold_q   <= '0;
         dump_pend_q  <= 1'b0;
         skid_q[0]    <= '0;
         skid_q[1]    <= '0;
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         skid_cnt_q   <= 2'd0;
      end else begin
         state_q      <= state_d;
         load_addr_q  <= load_addr_d;
         rd_addr_q    <= rd_addr_d;
         issue_left_q <= issue_left_d;
         out_left_q   <= out_left_d;
         err_q        <= err_d;
         done_q       <= done_d;
         start_q      <= start_d;
         acc_pend_q   <= acc_pend_d;
         acc_oor_q    <= acc_oor_d;
         acc_hold_q   <= acc_hold_d;
         dump_pend_q  <= dump_pend_d;
         skid_q       <= skid_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         skid_cnt_q   <= skid_cnt_d;
      end
   end

endmodule

// File: tb/tb_image_mem_host.sv
// Bench for image_mem_host with a reduced image size. The bench plays both
// the stream source/sink and the accelerator; a word-level memory model
// predicts every acc read and the result stream, which a negedge monitor
// checks against a queue of expected words.
module tb_image_mem_host;

   localparam int ADDR_W = 16;
   localparam int DEPTH  = 50688;
   localparam int IMG    = 128;
   localparam int RB     = 128;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              cmd_go = 1'b0;
   logic              busy, done, err;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [31:0]       out_data;
   logic [ADDR_W-1:0] acc_addr = '0;
   logic [31:0]       acc_dataR;
   logic [31:0]       acc_dataW = '0;
   logic              acc_en = 1'b0;
   logic              acc_we = 1'b0;
   logic              acc_start;
   logic              acc_finish = 1'b0;

   always #5 clk = ~clk;

   image_mem_host #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .IMG_WORDS(IMG), .RESULT_BASE(RB)) dut (
      .clk(clk), .reset(reset), .cmd_go(cmd_go), .busy(busy), .done(done), .err(err),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .acc_addr(acc_addr), .acc_dataR(acc_dataR), .acc_dataW(acc_dataW),
      .acc_en(acc_en), .acc_we(acc_we), .acc_start(acc_start), .acc_finish(acc_finish)
   );

   int checks = 0;
   int failures = 0;
   logic [31:0] mdl [int];
   logic [31:0] exp_q [$];
   int done_cnt = 0, start_cnt = 0, out_cnt = 0;
   logic prev_busy = 1'b0, prev_done = 1'b0, stall_q = 1'b0;
   logic [31:0] stall_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Monitor: output stream scoreboard, stall stability, done/start pulses.
   always @(negedge clk) begin
      if (!reset) begin
         prev_busy = 1'b0;
         prev_done = 1'b0;
         stall_q   = 1'b0;
      end else begin
         if (acc_start) start_cnt++;
         if (stall_q) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, stall_data);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out actual=%0h required=none", out_data);
            end else begin
               chk("out_data", out_data, exp_q.pop_front());
            end
            out_cnt++;
         end
         stall_q    = out_valid && !out_ready;
         stall_data = out_data;
         if (prev_done) chk("done_width", done, 1'b0);
         if (done) begin
            chk("busy_at_done", busy, 1'b0);
            chk("busy_before_done", prev_busy, 1'b1);
            done_cnt++;
         end
         prev_done = done;
         prev_busy = busy;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] d, input bit junk);
      int budget = 20;
      in_valid = 1'b1;
      in_data  = d;
      if (junk) begin
         acc_en = 1'b1; acc_we = 1'b1; acc_addr = 16'd300; acc_dataW = $urandom;
      end
      while (budget > 0) begin
         @(negedge clk);
         if (in_ready) break;
         budget--;
      end
      if (budget == 0) timeout("load_ready");
      tick();
      in_valid = 1'b0;
      acc_en   = 1'b0;
      acc_we   = 1'b0;
   endtask

   task automatic acc_wr(input logic [15:0] a, input logic [31:0] d, input bit fin);
      acc_en = 1'b1; acc_we = 1'b1; acc_addr = a; acc_dataW = d; acc_finish = fin;
      tick();
      acc_en = 1'b0; acc_we = 1'b0; acc_finish = 1'b0;
      if (int'(a) < DEPTH) mdl[int'(a)] = d;
   endtask

   task automatic acc_rd(input logic [15:0] a, output logic [31:0] d);
      acc_en = 1'b1; acc_we = 1'b0; acc_addr = a;
      tick();
      acc_en = 1'b0;
      d = acc_dataR;
   endtask

   // Accelerator model: result[i] = image[i] + 1, all but the last word.
   task automatic run_copy(input bit gaps);
      logic [31:0] v;
      for (int i = 0; i < IMG - 1; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) tick();
         acc_rd(16'(i), v);
         chk("acc_rd_img", v, mdl[i]);
         acc_wr(16'(RB + i), v + 32'd1, 1'b0);
      end
   endtask

   // Last copy word is written in the same cycle finish is raised.
   task automatic finish_last();
      logic [31:0] v;
      acc_rd(16'(IMG - 1), v);
      chk("acc_rd_last", v, mdl[IMG - 1]);
      acc_wr(16'(RB + IMG - 1), v + 32'd1, 1'b1);
      for (int i = 0; i < IMG; i++) exp_q.push_back(mdl[RB + i]);
   endtask

   task automatic dump_phase(input bit rand_ready, input int fin_hold, input bit junk,
                             output int first_lat, output int cycles);
      int start_done = done_cnt;
      int hold = fin_hold;
      first_lat = -1;
      cycles = 0;
      while (done_cnt == start_done && cycles < 8 * IMG + 50) begin
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         acc_finish = (hold > 0);
         if (hold > 0) hold--;
         if (junk) begin
            acc_en = 1'b1; acc_we = 1'b1; acc_addr = 16'd301; acc_dataW = $urandom;
         end
         @(negedge clk);
         if (first_lat < 0 && out_valid) first_lat = cycles;
         tick();
         cycles++;
      end
      if (done_cnt == start_done) timeout("dump_done");
      out_ready = 1'b1; acc_finish = 1'b0; acc_en = 1'b0; acc_we = 1'b0;
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] d;
      int lat, cyc;

      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_acc_start", acc_start, 1'b0);
      chk("rst_acc_dataR", acc_dataR, 32'h0);
      chk("rst_out_data", out_data, 32'h0);

      // Abort a partial load with reset.
      cmd_go = 1'b1; tick(); cmd_go = 1'b0;
      chk("load_busy", busy, 1'b1);
      chk("load_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 100; i++) send_word($urandom, 1'b0);
      reset = 1'b0;
      #2;
      chk("abort_busy", busy, 1'b0);
      chk("abort_in_ready", in_ready, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      chk("abort_idle_busy", busy, 1'b0);
      chk("abort_out_valid", out_valid, 1'b0);

      // Job 1: ramp image, full-throughput dump.
      start_cnt = 0; out_cnt = 0;
      cmd_go = 1'b1; tick(); cmd_go = 1'b0;
      for (int i = 0; i < IMG; i++) begin
         mdl[i] = 32'(i);
         send_word(32'(i), 1'b0);
      end
      chk("run_start", acc_start, 1'b1);
      chk("run_in_ready", in_ready, 1'b0);
      acc_finish = 1'b1; tick(); acc_finish = 1'b0;
      chk("start_one_cycle", acc_start, 1'b0);
      chk("early_finish_busy", busy, 1'b1);
      for (int i = 0; i < 4; i++) acc_wr(16'(300 + i), $urandom, 1'b0);
      run_copy(1'b1);
      acc_rd(16'd5, v);
      chk("acc_rd5", v, mdl[5]);
      tick();
      chk("acc_rd_hold", acc_dataR, mdl[5]);
      acc_wr(16'd5, 32'hA5A5_0005, 1'b0);
      acc_rd(16'd5, v);
      chk("wr_rd_same_addr", v, 32'hA5A5_0005);
      finish_last();
      dump_phase(1'b0, 0, 1'b1, lat, cyc);
      chk("first_valid_latency_ok", (lat >= 0 && lat <= 2), 1'b1);
      chk("full_throughput_ok", (cyc <= IMG + 3), 1'b1);
      chk("job1_start_pulses", start_cnt, 1);
      chk("job1_done_pulses", done_cnt, 1);
      chk("job1_out_words", out_cnt, IMG);
      chk("job1_queue_left", exp_q.size(), 0);

      // Job 2: random image with gaps and ignored acc traffic, range faults,
      // held finish, randomly stalled dump.
      start_cnt = 0; out_cnt = 0;
      cmd_go = 1'b1; tick(); cmd_go = 1'b0;
      chk("job2_err_cleared", err, 1'b0);
      for (int i = 0; i < IMG; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         d = $urandom;
         mdl[i] = d;
         send_word(d, (i != IMG - 1) && ($urandom_range(0, 1) == 1));
      end
      chk("job2_start", acc_start, 1'b1);
      cmd_go = 1'b1; tick(); cmd_go = 1'b0;
      chk("go_in_run_busy", busy, 1'b1);
      chk("go_in_run_in_ready", in_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         acc_rd(16'(300 + i), v);
         chk("ignored_acc_wr", v, mdl[300 + i]);
      end
      chk("err_before_oor", err, 1'b0);
      acc_wr(16'hFFFF, 32'hDEAD_BEEF, 1'b0);
      chk("err_after_oor_wr", err, 1'b1);
      acc_rd(16'hC600, v);
      chk("oor_rd_zero", v, 32'h0);
      run_copy(1'b1);
      finish_last();
      dump_phase(1'b1, 9, 1'b0, lat, cyc);
      chk("job2_start_pulses", start_cnt, 1);
      chk("job2_done_pulses", done_cnt, 2);
      chk("job2_out_words", out_cnt, IMG);
      chk("job2_queue_left", exp_q.size(), 0);
      repeat (3) tick();
      chk("idle_after_dump", busy, 1'b0);
      chk("err_sticky", err, 1'b1);
      cmd_go = 1'b1; tick(); cmd_go = 1'b0;
      chk("err_clear_on_go", err, 1'b0);
      chk("busy_on_go", busy, 1'b1);
      reset = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
